// File: rtl/xeng_tap_sched.sv
// Frame scheduler for the X-engine tap chain: arms, aligns to upstream sync,
// counts valid samples into per-antenna accumulation windows and tracks resyncs.
module xeng_tap_sched #(
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int N_ANTS              = 32,
  parameter int ANT_BITS            = 5,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ce,
  input  logic                           arm,
  input  logic                           disarm,
  input  logic                           sync_in,
  input  logic                           din_valid,
  output logic                           sync_out,
  output logic                           acc_dump,
  output logic                           frame_done,
  output logic [SERIAL_ACC_LEN_BITS-1:0] samp_idx,
  output logic [ANT_BITS-1:0]            win_idx,
  output logic                           running,
  output logic [CNT_WIDTH-1:0]           resync_cnt,
  output logic [1:0]                     state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [SERIAL_ACC_LEN_BITS-1:0] NS_LAST = '1;
  localparam logic [ANT_BITS-1:0]            NW_LAST = ANT_BITS'(N_ANTS - 1);

  state_t                         state_reg;
  logic [SERIAL_ACC_LEN_BITS-1:0] ns_reg;
  logic [ANT_BITS-1:0]            nw_reg;
  logic                           at_frame_start;
  logic                           ns_last;
  logic                           nw_last;

  assign at_frame_start = (ns_reg == '0) && (nw_reg == '0);
  assign ns_last        = (ns_reg == NS_LAST);
  assign nw_last        = (nw_reg == NW_LAST);
  assign state          = state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      ns_reg     <= '0;
      nw_reg     <= '0;
      sync_out   <= 1'b0;
      acc_dump   <= 1'b0;
      frame_done <= 1'b0;
      samp_idx   <= '0;
      win_idx    <= '0;
      running    <= 1'b0;
      resync_cnt <= '0;
    end else if (ce) begin
      // Pulses last one effective cycle; with ce low they simply hold.
      sync_out   <= 1'b0;
      acc_dump   <= 1'b0;
      frame_done <= 1'b0;
      if (disarm) begin
        state_reg <= IDLE;
        running   <= 1'b0;
        ns_reg    <= '0;
        nw_reg    <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (arm) state_reg <= ARMED;
          end
          ARMED: begin
            if (sync_in) begin
              state_reg <= RUN;
              running   <= 1'b1;
              sync_out  <= 1'b1;
              ns_reg    <= '0;
              nw_reg    <= '0;
            end
          end
          RUN: begin
            if (sync_in) begin
              sync_out <= 1'b1;
              // A sync landing mid-frame means upstream slipped: count it and realign.
              if (!at_frame_start) begin
                if (resync_cnt != '1) resync_cnt <= resync_cnt + 1'b1;
                ns_reg <= '0;
                nw_reg <= '0;
              end
            end else if (din_valid) begin
              samp_idx   <= ns_reg;
              win_idx    <= nw_reg;
              acc_dump   <= ns_last;
              frame_done <= ns_last && nw_last;
              ns_reg     <= ns_reg + 1'b1;
              if (ns_last) nw_reg <= nw_last ? '0 : nw_reg + 1'b1;
            end
          end
          default: begin
            state_reg <= IDLE;
            running   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xeng_tap_sched.sv
// Randomised self-checking bench for xeng_tap_sched against a frame-position model.
module tb_xeng_tap_sched;
  localparam int SB = 2;
  localparam int NA = 3;
  localparam int AB = 2;
  // Narrow resync counter so saturation is reachable in a short run.
  localparam int CW = 8;
  localparam int WLEN = 1 << SB;
  localparam int FLEN = WLEN * NA;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0, arm = 1'b0, disarm = 1'b0, sync_in = 1'b0, din_valid = 1'b0;
  logic sync_out, acc_dump, frame_done, running;
  logic [SB-1:0] samp_idx;
  logic [AB-1:0] win_idx;
  logic [CW-1:0] resync_cnt;
  logic [1:0] state;

  xeng_tap_sched #(
    .SERIAL_ACC_LEN_BITS(SB), .N_ANTS(NA), .ANT_BITS(AB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .arm(arm), .disarm(disarm),
    .sync_in(sync_in), .din_valid(din_valid), .sync_out(sync_out),
    .acc_dump(acc_dump), .frame_done(frame_done), .samp_idx(samp_idx),
    .win_idx(win_idx), .running(running), .resync_cnt(resync_cnt), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Model: the frame is tracked as a single position 0..FLEN-1 since last alignment.
  int m_state, m_pos, m_samp, m_win, m_resync;
  bit m_sync, m_dump, m_fd;

  logic [17:0] dut_vec;
  assign dut_vec = {sync_out, acc_dump, frame_done, samp_idx, win_idx, running, resync_cnt, state};

  function automatic logic [17:0] exp_vec();
    return {m_sync, m_dump, m_fd, SB'(m_samp), AB'(m_win), (m_state == 2),
            CW'(m_resync), 2'(m_state)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_samp = 0; m_win = 0; m_resync = 0;
    m_sync = 0; m_dump = 0; m_fd = 0;
  endtask

  task automatic cycle(input bit a, input bit d, input bit s, input bit v, input bit c);
    arm = a; disarm = d; sync_in = s; din_valid = v; ce = c;
    @(posedge clk); #1;
    if (c) begin
      m_sync = 0; m_dump = 0; m_fd = 0;
      if (d) begin
        m_state = 0; m_pos = 0;
      end else if (m_state == 0) begin
        if (a) m_state = 1;
      end else if (m_state == 1) begin
        if (s) begin m_state = 2; m_sync = 1; m_pos = 0; end
      end else if (s) begin
        m_sync = 1;
        if (m_pos != 0) begin
          m_resync = (m_resync < CMAX) ? m_resync + 1 : CMAX;
          m_pos = 0;
        end
      end else if (v) begin
        m_samp = m_pos % WLEN;
        m_win  = m_pos / WLEN;
        m_dump = (m_samp == WLEN - 1);
        m_fd   = (m_pos == FLEN - 1);
        m_pos  = (m_pos + 1) % FLEN;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== 18'd0) $display("FAIL reset_outputs: got %h expected %h", dut_vec, 18'd0);
    else passes++;
    rst_n = 1'b1;
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (dut_vec !== exp_vec()) $display("FAIL reset_idle: got %h expected %h", dut_vec, exp_vec());
    else passes++;
    $display("test_reset done");
  endtask

  task automatic test_frame();
    int dumps = 0;
    cycle(1, 0, 0, 0, 1);
    for (int c = 2; c < 10; c++) cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 1, 0, 1);
    checks++;
    if (state !== 2'd2 || sync_out !== 1'b1)
      $display("FAIL frame_start: state=%0d sync_out=%0b expected state=2 sync_out=1", state, sync_out);
    else passes++;
    for (int i = 0; i < FLEN; i++) begin
      cycle(0, 0, 0, 1, 1);
      dumps += acc_dump;
      checks++;
      if (acc_dump !== ((i % 4) == 3) || frame_done !== (i == 11) ||
          win_idx !== AB'(i / 4) || samp_idx !== SB'(i % 4))
        $display("FAIL frame_sample%0d: dump=%0b fd=%0b samp=%0d win=%0d expected dump=%0b fd=%0b samp=%0d win=%0d",
                 i, acc_dump, frame_done, samp_idx, win_idx, (i % 4) == 3, i == 11, i % 4, i / 4);
      else passes++;
    end
    checks++;
    if (dumps != 3) $display("FAIL frame_dump_count: got %0d expected 3", dumps);
    else passes++;
    $display("test_frame done");
  endtask

  task automatic test_aligned_sync();
    cycle(0, 0, 1, 1, 1);
    checks++;
    if (sync_out !== 1'b1 || resync_cnt !== '0)
      $display("FAIL aligned_sync: sync_out=%0b resync=%0d expected 1 and 0", sync_out, resync_cnt);
    else passes++;
    cycle(0, 0, 0, 1, 1);
    checks++;
    if (samp_idx !== '0 || win_idx !== '0 || dut_vec !== exp_vec())
      $display("FAIL aligned_restart: got %h expected %h", dut_vec, exp_vec());
    else passes++;
    $display("test_aligned_sync done");
  endtask

  task automatic test_misaligned();
    repeat (4) cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 1, 0, 1);
    checks++;
    if (resync_cnt !== CW'(1) || sync_out !== 1'b1)
      $display("FAIL misaligned_first: resync=%0d sync_out=%0b expected 1 and 1", resync_cnt, sync_out);
    else passes++;
    cycle(0, 0, 0, 1, 1);
    checks++;
    if (samp_idx !== '0 || win_idx !== '0)
      $display("FAIL misaligned_restart: samp=%0d win=%0d expected 0 0", samp_idx, win_idx);
    else passes++;
    for (int i = 0; i < CMAX + 10; i++) begin
      cycle(0, 0, 1, 0, 1);
      checks++;
      if (dut_vec !== exp_vec()) $display("FAIL saturate_iter%0d: got %h expected %h", i, dut_vec, exp_vec());
      else passes++;
      cycle(0, 0, 0, 1, 1);
    end
    checks++;
    if (resync_cnt !== CW'(CMAX)) $display("FAIL saturate_final: got %0d expected %0d", resync_cnt, CMAX);
    else passes++;
    $display("test_misaligned done");
  endtask

  task automatic test_ce();
    for (int i = 0; i < 40; i++) begin
      cycle(0, 0, 0, (i % 2) == 0, (i % 4) < 2);
      checks++;
      if (dut_vec !== exp_vec()) $display("FAIL ce_toggle%0d: got %h expected %h", i, dut_vec, exp_vec());
      else passes++;
    end
    for (int i = 0; i < 80; i++) begin
      cycle(0, 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1));
      checks++;
      if (dut_vec !== exp_vec()) $display("FAIL ce_random%0d: got %h expected %h", i, dut_vec, exp_vec());
      else passes++;
    end
    $display("test_ce done");
  endtask

  task automatic test_control();
    cycle(0, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    checks++;
    if (sync_out !== 1'b0 || state !== 2'd0)
      $display("FAIL idle_sync: sync_out=%0b state=%0d expected 0 0", sync_out, state);
    else passes++;
    cycle(1, 1, 0, 0, 1);
    checks++;
    if (state !== 2'd0) $display("FAIL arm_disarm: state=%0d expected 0", state);
    else passes++;
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    repeat (6) cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 0, 1, 1);
    checks++;
    if (state !== 2'd0 || running !== 1'b0 || dut_vec !== exp_vec())
      $display("FAIL disarm_mid: got %h expected %h", dut_vec, exp_vec());
    else passes++;
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    cycle(0, 0, 0, 1, 1);
    checks++;
    if (samp_idx !== '0 || win_idx !== '0 || dut_vec !== exp_vec())
      $display("FAIL rearm_first: got %h expected %h", dut_vec, exp_vec());
    else passes++;
    $display("test_control done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
      checks++;
      if (dut_vec !== exp_vec()) $display("FAIL random%0d: got %h expected %h", i, dut_vec, exp_vec());
      else passes++;
    end
    $display("test_random done");
  endtask

  task automatic test_async_reset();
    cycle(0, 1, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    repeat (6) cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== 18'd0 || state !== 2'd0)
      $display("FAIL async_reset: got %h expected %h", dut_vec, 18'd0);
    else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(0, 0, 1, 1, 1);
    checks++;
    if (dut_vec !== exp_vec() || sync_out !== 1'b0)
      $display("FAIL post_reset_sync: got %h expected %h", dut_vec, exp_vec());
    else passes++;
    $display("test_async_reset done");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_frame();
    test_aligned_sync();
    test_misaligned();
    test_ce();
    test_control();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/xeng_tap_sched.md
# xeng_tap_sched

Frame scheduler for the X-engine tap chain (auto and baseline taps). It arms on software command, aligns to the upstream sync, and emits the chain sync. It then counts valid samples into serial-accumulation windows, one window per antenna slot, and flags each accumulation dump and frame end. Misaligned syncs are detected and counted, and the block re-aligns on them.

## Interface
- SERIAL_ACC_LEN_BITS, 7: samples per window = 2^SERIAL_ACC_LEN_BITS.
- N_ANTS, 32: windows per frame (≥2, any integer).
- ANT_BITS, 5: width of window index; ceil(log2(N_ANTS)) ≤ ANT_BITS.
- CNT_WIDTH, 16: width of resync counter.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ce  in  1  clock enable; when low all state and outputs hold, all inputs ignored.
- arm  in  1  single-cycle arm request.
- disarm  in  1  single-cycle disarm request.
- sync_in  in  1  upstream sync pulse.
- din_valid  in  1  upstream sample valid.
- sync_out  out  1  chain sync pulse to taps.
- acc_dump  out  1  pulse: last sample of a window counted.
- frame_done  out  1  pulse: last sample of last window counted.
- samp_idx  out  SERIAL_ACC_LEN_BITS  index within window of the sample last counted.
- win_idx  out  ANT_BITS  window index of the sample last counted.
- running  out  1  high in RUN.
- resync_cnt  out  CNT_WIDTH  saturating count of misaligned syncs.
- state  out  2  IDLE=0, ARMED=1, RUN=2.

## Operation
- Reset: state IDLE; all outputs 0; internal next-sample counters (ns, nw) = 0.
- An effective cycle is ce=1. A counted sample is an effective cycle with state RUN, din_valid=1, sync_in=0.
- IDLE: arm → ARMED. sync_in ignored.
- ARMED: sync_in → RUN, pulse sync_out, ns=nw=0. din_valid ignored.
- Any state: disarm → IDLE and counters cleared. disarm beats arm and sync_in in the same cycle.
- RUN, counted sample:
  - Register samp_idx=ns and win_idx=nw.
  - acc_dump=1 iff ns=2^SERIAL_ACC_LEN_BITS−1.
  - frame_done=1 iff acc_dump and nw=N_ANTS−1.
  - Advance ns. On ns wrap, advance nw, with nw wrapping to 0 after N_ANTS−1.
- RUN, sync_in:
  - Always pulse sync_out.
  - Aligned if ns=0 and nw=0 beforehand, e.g. just after frame_done or before any sample. Aligned syncs change nothing else.
  - Otherwise misaligned: resync_cnt += 1, saturating at all-ones, and ns=nw=0.
  - The sync cycle itself is never counted, even if din_valid=1.
- RUN, din_valid=0 and no sync: counters hold.
- resync_cnt is cleared only by reset; it is not cleared by disarm.

## Timing
- All outputs registered.
- sync_in to sync_out latency: 1 effective cycle.
- Counted sample to samp_idx/win_idx/acc_dump/frame_done: 1 cycle.
- Pulses (sync_out, acc_dump, frame_done) are high for exactly one cycle after their cause when ce=1. If ce falls during a pulse cycle, the pulse holds until the next effective cycle, then clears.
- samp_idx and win_idx hold between counted samples.
- running and state update 1 cycle after the transition cause.
- Mid-operation rst_n assertion: outputs go to 0 immediately (async). Operation restarts only after a new arm and sync.

## Test plan
Bench parameters: SERIAL_ACC_LEN_BITS=2, N_ANTS=3, ANT_BITS=2.
- Reset, then arm, then sync_in at cycle 10 → state 2 and sync_out=1 at cycle 11. Then 12 consecutive din_valid cycles → acc_dump at outputs 4, 8, 12, frame_done only at the 12th, win_idx sequence 0,0,0,0,1,…,2.
- sync_in exactly after frame_done → sync_out pulse, resync_cnt stays 0, counting restarts at samp_idx 0 win_idx 0.
- sync_in after 5 samples → resync_cnt=1, sync_out pulse, next sample shows samp_idx 0, win_idx 0. Force 65536 misaligned syncs → count stays at 0xFFFF.
- din_valid toggling 1,0,1,0 with ce held low on alternate cycles → only ce=1 & valid cycles advance samp_idx, and pulses are stretched per the ce rule.
- sync_in while IDLE → no sync_out. arm+disarm in the same cycle → stays IDLE. disarm mid-window → IDLE, running=0, and after re-arm plus sync the first sample shows samp_idx 0.
- rst_n low mid-window with ce=0 → all outputs 0 immediately, state 0.
